// File: rtl/alu_seq_pkg.sv
// Shared widths, ALU op codes and sequencer FSM states for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_XOR = 2'b10,
        OP_SHL = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO: registered pointers and occupancy count, full/empty flags.
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap on their natural width because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands and issues them one at a time, holding each result until accepted.
// Optional accumulator operand feature enabled by defining ALU_SEQ_ACCUM_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [1:0]  cmd_sel,
    input  logic        cmd_use_acc,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_carry,
    output logic        res_zero,
    output logic        busy
);

`ifdef ALU_SEQ_ACCUM_EN
    localparam int unsigned CMD_W = 2*DATA_W + SEL_W + 1;
`else
    localparam int unsigned CMD_W = 2*DATA_W + SEL_W;
`endif

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_carry_q, res_carry_d;
    logic                res_zero_q, res_zero_d;
    logic                res_valid_q, res_valid_d;
    logic                load_next;

    logic [CMD_W-1:0]    fifo_din, fifo_dout;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]   head_a, head_b;
    logic [SEL_W-1:0]    head_sel;

`ifdef ALU_SEQ_ACCUM_EN
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                head_use_acc;
    assign fifo_din = {cmd_a, cmd_b, cmd_sel, cmd_use_acc};
    assign {head_a, head_b, head_sel, head_use_acc} = fifo_dout;
`else
    logic                unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign fifo_din = {cmd_a, cmd_b, cmd_sel};
    assign {head_a, head_b, head_sel} = fifo_dout;
`endif

    assign cmd_ready = rst_n && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        load_next   = 1'b0;
        fifo_pop    = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
        acc_d       = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_next = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                res_data_d  = alu_out;
                res_carry_d = alu_carry;
                res_zero_d  = alu_zero;
                res_valid_d = 1'b1;
                state_d     = HOLD;
`ifdef ALU_SEQ_ACCUM_EN
                acc_d       = alu_out;
`endif
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load_next = 1'b1;
                        state_d   = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // acc_q already holds the previous capture when the next command is popped.
        if (load_next) begin
            fifo_pop = 1'b1;
            a_d      = head_a;
            b_d      = head_b;
            sel_d    = head_sel;
`ifdef ALU_SEQ_ACCUM_EN
            if (head_use_acc) begin
                a_d = acc_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
`ifdef ALU_SEQ_ACCUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign res_valid = res_valid_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed steps plus randomized traffic vs. a queue model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [1:0] cmd_sel;
    logic       cmd_use_acc;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_sel;
    logic       alu_carry, alu_zero;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_carry, res_zero;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_res = 0;

    logic [9:0] exp_q[$];
    logic [7:0] model_acc = 8'd0;
    logic [7:0] mon_a;
    logic [9:0] mon_r, mon_e;
    logic       hold_pend = 1'b0;
    logic [9:0] hold_val = '0;

    always #5 clk = ~clk;

    // Reference ALU: result {carry, zero, data}; carry is always the 8-bit add carry.
    function automatic logic [9:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        int unsigned ua, ub, r;
        ua = a;
        ub = b;
        case (sel)
            2'd0:    r = (ua + ub) % 256;
            2'd1:    r = (ua * ub) % 256;
            2'd2:    r = ua ^ ub;
            default: r = (ua * 2) % 256;
        endcase
        return {(ua + ub) > 255, r == 0, r[7:0]};
    endfunction

    assign {alu_carry, alu_zero, alu_out} = ref_alu(alu_a, alu_b, alu_sel);

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_sel     (cmd_sel),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: model each accepted command in order, compare each result handshake.
    always @(negedge clk) begin
        if (hold_pend) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_result", {res_carry, res_zero, res_data}, hold_val);
        end
        hold_pend = rst_n && res_valid && !res_ready;
        hold_val  = {res_carry, res_zero, res_data};
        if (rst_n && cmd_valid && cmd_ready) begin
            n_acc++;
            mon_a = cmd_a;
`ifdef ALU_SEQ_ACCUM_EN
            if (cmd_use_acc) mon_a = model_acc;
`endif
            mon_r = ref_alu(mon_a, cmd_b, cmd_sel);
            model_acc = mon_r[7:0];
            exp_q.push_back(mon_r);
        end
        if (rst_n && res_valid && res_ready) begin
            n_res++;
            chk("result_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("result_in_order", {res_carry, res_zero, res_data}, mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel, input logic u);
        bit done = 1'b0;
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_sel     = sel;
        cmd_use_acc = u;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic wait_res(input string tag, input logic [7:0] d, input logic c, input logic z);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
            if (!seen) tick();
        end
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_carry"}, res_carry, c);
        chk({tag, "_zero"}, res_zero, z);
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy || res_valid); i++) tick();
    endtask

    initial begin
        int n0, a0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_sel = '0; cmd_use_acc = 1'b0; res_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_flags", {res_carry, res_zero}, 0);
        chk("rst_alu_ops", {alu_a, alu_b, alu_sel}, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);
        tick();

        // add 200+100: three-cycle latency, carry out
        res_ready = 1'b1;
        send(8'd200, 8'd100, 2'b00, 1'b0);
        @(negedge clk); chk("lat_c1_valid", res_valid, 0); tick();
        @(negedge clk); chk("lat_c2_valid", res_valid, 0); tick();
        @(negedge clk);
        chk("lat_c3_valid", res_valid, 1);
        chk("add_data", res_data, 44);
        chk("add_carry", res_carry, 1);
        chk("add_zero", res_zero, 0);
        tick();

        send(8'd16, 8'd16, 2'b01, 1'b0);
        wait_res("mul", 8'h00, 1'b0, 1'b1);
        send(8'h81, 8'h00, 2'b11, 1'b0);
        wait_res("shl", 8'h02, 1'b0, 1'b0);
        send(8'h5a, 8'h0f, 2'b10, 1'b0);
        wait_res("xor", 8'h55, 1'b0, 1'b0);
        wait_idle();

        // Backpressure: five fit (one in operand regs + four queued), sixth stalls
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_a = 8'(10 + i); cmd_b = 8'(i); cmd_sel = 2'b00; cmd_use_acc = 1'b0;
            @(negedge clk);
            chk($sformatf("bp_ready%0d", i), cmd_ready, i < 5);
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_data", res_data, 10);
            tick();
        end
        n0 = n_res;
        res_ready = 1'b1;
        wait_idle();
        chk("bp_results", n_res - n0, 5);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Accumulator operand
        send(8'd5, 8'd3, 2'b00, 1'b0);
        wait_res("acc1", 8'd8, 1'b0, 1'b0);
        send(8'd7, 8'd2, 2'b00, 1'b1);
`ifdef ALU_SEQ_ACCUM_EN
        wait_res("acc2", 8'd10, 1'b0, 1'b0);
`else
        wait_res("acc2", 8'd9, 1'b0, 1'b0);
`endif
        wait_idle();

        // Reset while holding a result with three commands queued
        res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 8'(i), 2'b00, 1'b0);
        @(negedge clk);
        chk("pre_rst_hold", res_valid, 1);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        model_acc = 8'd0;
        @(negedge clk);
        chk("rst_mid_cmd_ready", cmd_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_res_valid", res_valid, 0);
        chk("rst_mid_busy", busy, 0);
        tick();
        n0 = n_res;
        res_ready = 1'b1;
        repeat (10) tick();
        chk("rst_no_stale", n_res - n0, 0);
        chk("rst_still_idle", {busy, res_valid}, 0);

        // Random traffic: 1000 commands with random valid/ready
        a0 = n_acc;
        n0 = n_res;
        for (int cyc = 0; cyc < 20000 && (n_acc - a0) < 1000; cyc++) begin
            cmd_valid   = ($urandom_range(0, 3) != 0);
            cmd_a       = 8'($urandom);
            cmd_b       = 8'($urandom);
            cmd_sel     = 2'($urandom);
            cmd_use_acc = 1'($urandom);
            res_ready   = 1'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        chk("rand_accepted", n_acc - a0, 1000);
        res_ready = 1'b1;
        wait_idle();
        chk("rand_results", n_res - n0, 1000);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
